// File: rtl/spi_reg_pkg.sv
// Shared constants, types and helpers for the SPI register controller.
// Frame layout: bit15 WR, bits14:8 ADDR, bits7:0 DATA.
package spi_reg_pkg;

    localparam int FRAME_W  = 16;
    localparam int ADDR_W   = 7;
    localparam int WR_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    localparam logic [7:0] ERR_DATA = 8'hEE;

    // Read-only locations sit directly above the read/write bank.
    localparam logic [ADDR_W-1:0] STATUS_OFS = 7'd0;
    localparam logic [ADDR_W-1:0] ERRCNT_OFS = 7'd1;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;
    typedef enum logic [1:0] {K_WRITE, K_READ, K_ERR} kind_t;

    function automatic kind_t classify(input logic [FRAME_W-1:0] frame,
                                       input logic [ADDR_W-1:0]  num_rw);
        logic [ADDR_W-1:0] addr;
        kind_t             kind;
        addr = frame[ADDR_MSB:ADDR_LSB];
        if (frame[WR_BIT] && (addr < num_rw))
            kind = K_WRITE;
        else if (!frame[WR_BIT] && (addr <= num_rw + ERRCNT_OFS))
            kind = K_READ;
        else
            kind = K_ERR;
        return kind;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] value,
                                           input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, value} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Frame interface between the SPI slave receiver (master modport)
// and the register controller (slave modport).
interface spi_reg_ctrl_if;
    import spi_reg_pkg::*;

    logic [FRAME_W-1:0] rx_data;
    logic               rx_flag;
    logic [FRAME_W-1:0] tx_data;

    modport master (output rx_data, output rx_flag, input tx_data);
    modport slave  (input rx_data, input rx_flag, output tx_data);

endinterface

// File: rtl/spi_reg_bank.sv
// Bank of NUM_RW 8-bit config registers: one write port, bulk default
// load, and a combinational read mux.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int         NUM_RW      = 6,
    parameter logic [7:0] CFG_RST_VAL = 8'h00
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                load_dflt,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [7:0]          rd_data,
    output logic [NUM_RW*8-1:0] cfg_flat
);

    logic [7:0] regs [NUM_RW];

    // NOTE: the bank is flops, not RAM, so every entry gets a reset value.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_RW; k++) regs[k] <= CFG_RST_VAL;
        end else if (load_dflt) begin
            for (int k = 0; k < NUM_RW; k++) regs[k] <= CFG_RST_VAL;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_RW; k++)
                if (wr_addr == ADDR_W'(k)) regs[k] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RW; k++)
            if (rd_addr == ADDR_W'(k)) rd_data = regs[k];
    end

    for (genvar k = 0; k < NUM_RW; k++) begin : g_flat
        assign cfg_flat[8*k +: 8] = regs[k];
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register command controller behind the 16-bit SPI slave.
// Optional watchdog built only when SPI_REG_WDT_EN is defined.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         NUM_RW      = 6,
    parameter logic [7:0] CFG_RST_VAL = 8'h00,
    parameter int         WDT_CYCLES  = 10_000_000
) (
    input  logic                clk_in,
    input  logic                rst,
    spi_reg_ctrl_if.slave       spi,
    input  logic [7:0]          status_in,
    output logic [NUM_RW*8-1:0] cfg_regs,
    output logic                cfg_wr_pulse,
    output logic [ADDR_W-1:0]   cfg_wr_addr,
    output logic [7:0]          err_cnt,
    output logic                busy,
    output logic                wdt_timeout
);

    if (NUM_RW < 1 || NUM_RW > 126 || WDT_CYCLES < 2 || WDT_CYCLES > (1 << 24)) begin : g_param_check
        $error("spi_reg_ctrl: NUM_RW or WDT_CYCLES out of range");
    end

    localparam logic [ADDR_W-1:0] NUM_RW_A    = ADDR_W'(NUM_RW);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = NUM_RW_A + STATUS_OFS;
    localparam logic [ADDR_W-1:0] ADDR_ERRCNT = NUM_RW_A + ERRCNT_OFS;

    state_t               state_q, state_d;
    logic                 rx_flag_d;
    logic                 frame_evt;
    logic [FRAME_W-1:0]   frame_q;
    kind_t                kind_q;
    logic [7:0]           err_cnt_q;
    logic [FRAME_W-1:0]   tx_data_q;
    logic                 latch_frame, decode_en, exec_en, resp_en;
    logic                 overrun, wr_en, load_dflt;
    logic [1:0]           err_inc;
    logic [ADDR_W-1:0]    frame_addr;
    logic [7:0]           frame_dat, bank_rd, rd_val;
    logic [FRAME_W-1:0]   resp_word;

    assign frame_evt  = spi.rx_flag & ~rx_flag_d;
    assign frame_addr = frame_q[ADDR_MSB:ADDR_LSB];
    assign frame_dat  = frame_q[DATA_MSB:0];

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: defaults first so every path assigns every output (no latches).
    always_comb begin
        state_d     = state_q;
        latch_frame = 1'b0;
        decode_en   = 1'b0;
        exec_en     = 1'b0;
        resp_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_evt) begin
                    latch_frame = 1'b1;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                decode_en = 1'b1;
                state_d   = EXEC;
            end
            EXEC: begin
                exec_en = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                resp_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign overrun = frame_evt && busy;
    assign wr_en   = exec_en && (kind_q == K_WRITE);
    assign err_inc = {1'b0, exec_en && (kind_q == K_ERR)} + {1'b0, overrun};

    assign cfg_wr_pulse = wr_en;
    assign cfg_wr_addr  = wr_en ? frame_addr : '0;

    spi_reg_bank #(
        .NUM_RW      (NUM_RW),
        .CFG_RST_VAL (CFG_RST_VAL)
    ) u_bank (
        .clk_in    (clk_in),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (frame_addr),
        .wr_data   (frame_dat),
        .load_dflt (load_dflt),
        .rd_addr   (frame_addr),
        .rd_data   (bank_rd),
        .cfg_flat  (cfg_regs)
    );

    // status_in is muxed here and only captured when RESP loads tx_data.
    always_comb begin
        rd_val = bank_rd;
        if (frame_addr == ADDR_STATUS)      rd_val = status_in;
        else if (frame_addr == ADDR_ERRCNT) rd_val = err_cnt_q;
    end

    always_comb begin
        resp_word = {1'b1, frame_addr, ERR_DATA};
        case (kind_q)
            K_WRITE: resp_word = {1'b0, frame_addr, frame_dat};
            K_READ:  resp_word = {1'b0, frame_addr, rd_val};
            default: resp_word = {1'b1, frame_addr, ERR_DATA};
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rx_flag_d <= 1'b0;
            frame_q   <= '0;
            kind_q    <= K_ERR;
            err_cnt_q <= '0;
            tx_data_q <= '0;
        end else begin
            rx_flag_d <= spi.rx_flag;
            if (latch_frame)    frame_q   <= spi.rx_data;
            if (decode_en)      kind_q    <= classify(frame_q, NUM_RW_A);
            if (err_inc != '0)  err_cnt_q <= sat_add(err_cnt_q, err_inc);
            if (resp_en)        tx_data_q <= resp_word;
        end
    end

    assign spi.tx_data = tx_data_q;
    assign err_cnt     = err_cnt_q;

`ifdef SPI_REG_WDT_EN
    localparam logic [23:0] WDT_LAST = 24'(WDT_CYCLES - 1);

    logic [23:0] wdt_cnt_q;
    logic        wdt_q;
    logic        wdt_kick;

    // Only frames that actually did a read or write keep the config alive.
    assign wdt_kick  = exec_en && (kind_q != K_ERR);
    assign load_dflt = (wdt_cnt_q == WDT_LAST) && !wdt_kick;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wdt_cnt_q <= '0;
            wdt_q     <= 1'b0;
        end else begin
            wdt_q <= load_dflt;
            if (wdt_kick || load_dflt) wdt_cnt_q <= '0;
            else                       wdt_cnt_q <= wdt_cnt_q + 24'd1;
        end
    end

    assign wdt_timeout = wdt_q;
`else
    assign load_dflt   = 1'b0;
    assign wdt_timeout = 1'b0;
`endif

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command controller sitting behind the 16-bit SPI slave receiver.
- Consumes each completed frame (rx_data / rx_flag), decodes it as a register read or write, and updates a bank of 8-bit configuration registers.
- Prepares the 16-bit response word that the slave shifts out on the next frame.
- Owns the configuration seen by the rest of the design and counts protocol errors.

Parameters:
- NUM_RW, 6: number of read/write config registers, addresses 0..NUM_RW-1.
- CFG_RST_VAL, 8'h00: reset/default value of every config register.
- WDT_CYCLES, 10_000_000: watchdog timeout in clk_in cycles (used only with the optional feature).

Ports:
- clk_in  in  1  system clock; the SPI slave runs on the same clock.
- rst  in  1  reset; asynchronous, active-high.
- rx_data  in  16  last completed frame from the SPI slave.
- rx_flag  in  1  slave level flag: rises when CS goes high (frame done), falls on the next CS fall.
- status_in  in  8  read-only status byte, readable at address NUM_RW.
- tx_data  out  16  response word loaded by the slave at the next CS fall.
- cfg_regs  out  NUM_RW*8  flattened config registers; register k occupies bits [8k+7:8k].
- cfg_wr_pulse  out  1  one-cycle strobe on each successful write.
- cfg_wr_addr  out  7  address of that write; valid with cfg_wr_pulse.
- err_cnt  out  8  saturating protocol error count, readable at address NUM_RW+1.
- busy  out  1  high while a frame is being processed.
- wdt_timeout  out  1  one-cycle watchdog strobe; tied 0 when the feature is absent.

Behaviour:
- Frame format: bit15 = WR (1 = write, 0 = read); bits14:8 = ADDR; bits7:0 = DATA (ignored on read).
- Reset (async, rst=1):
  - FSM returns to IDLE.
  - All cfg regs = CFG_RST_VAL; tx_data = 16'h0000; err_cnt = 0.
  - cfg_wr_pulse, cfg_wr_addr, busy, wdt_timeout = 0.
  - The rx_flag delay flop is cleared. A frame in flight is discarded and no write occurs.
- Edge detect: frame_evt = rx_flag & ~rx_flag_d, where rx_flag_d is registered.
- FSM states:
  - IDLE: on frame_evt, latch rx_data into the frame register -> DECODE.
  - DECODE: classify the frame:
    - WR and ADDR < NUM_RW: write.
    - !WR and ADDR ≤ NUM_RW+1: read.
    - Anything else: error (out-of-range address, or write to NUM_RW / NUM_RW+1).
    - Always -> EXEC.
  - EXEC:
    - Write: update the register and assert cfg_wr_pulse/cfg_wr_addr for this cycle only.
    - Error: err_cnt += 1, saturating at 8'hFF.
    - -> RESP.
  - RESP: load tx_data -> IDLE.
    - Write: {1'b0, ADDR, new value}.
    - Read: {1'b0, ADDR, value}; value = reg[ADDR], status_in, or err_cnt.
    - Error: {1'b1, ADDR, 8'hEE}.
- Latency:
  - frame_evt is high in cycle N; state = DECODE in N+1, EXEC in N+2, RESP in N+3.
  - tx_data is updated at the end of N+3 and holds until the next frame.
- busy is high in DECODE, EXEC and RESP.
- Overrun: frame_evt while busy → the frame is dropped and err_cnt += 1 (saturating). tx_data still completes for the frame in progress.
- The status_in value is sampled in RESP, not earlier.
- err_cnt is not cleared by reading it; only reset clears it.
- Masters must leave ≥ 4 clk_in cycles plus the slave's 3-cycle synchroniser delay between CS rise and the next CS fall; the response is then guaranteed in time.

Optional Feature:
- Macro: SPI_REG_WDT_EN.
- With the macro:
  - A 24-bit counter increments each cycle and clears on every non-error frame (successful read or write) reaching EXEC.
  - At WDT_CYCLES-1 it asserts wdt_timeout for 1 cycle, restores all cfg regs to CFG_RST_VAL, and clears itself.
  - Error frames do not clear it.
- Without the macro: no counter is built, wdt_timeout = 0 constantly, and cfg regs change only by write or reset.

Decomposition:
- Package spi_reg_pkg holds:
  - Frame field positions (WR_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7).
  - ERR_DATA = 8'hEE.
  - The FSM state enum {IDLE, DECODE, EXEC, RESP}.
  - Helper constants for the status/err_cnt address offsets.
- One natural sub-module: spi_reg_bank, containing the NUM_RW×8 register array with write port, reset/default load (also used by the watchdog), and combinational read mux.

Test Plan:
- Write then read back:
  - rx_data=16'h8255, rx_flag rises.
  - N+2: cfg_wr_pulse=1 with cfg_wr_addr=2; reg2=8'h55.
  - N+4: tx_data=16'h0255.
  - Read frame 16'h0200 → tx_data=16'h0255.
- Read-only / out of range:
  - Write 16'h8612 (addr 6 = NUM_RW) → tx_data=16'h86EE, err_cnt=1, no cfg_wr_pulse.
  - Read 16'h4000 → tx_data=16'hC0EE, err_cnt=2.
- Status and counter read: status_in=8'hA5, read 16'h0600 → tx_data=16'h06A5; read 16'h0700 → tx_data=16'h07<err_cnt>.
- Overrun and saturation:
  - Pulse rx_flag low→high again 1 cycle after frame_evt → err_cnt +1 and the first response is intact.
  - Drive 300 error frames → err_cnt holds 8'hFF.
- Async reset mid-frame: assert rst in EXEC of write 16'h8133 → reg1 stays CFG_RST_VAL, tx_data=0, busy=0 immediately (no clock edge needed).
- SPI_REG_WDT_EN with WDT_CYCLES=100:
  - Write reg0=8'h7F, then idle 100 cycles → wdt_timeout pulses once and reg0=8'h00.
  - With the macro off → reg0 stays 8'h7F.
